// File: rtl/clock_ratio_pkg.sv
// Shared FSM encoding, period constants and period-to-selection decode
// for clock_ratio_detector and its edge/period counter.
package clock_ratio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_CHECK,
    ST_LOCKED
  } state_e;

  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [CNT_W-1:0] PERIOD_DIV2  = 6'd2;
  localparam logic [CNT_W-1:0] PERIOD_DIV4  = 6'd4;
  localparam logic [CNT_W-1:0] PERIOD_DIV8  = 6'd8;
  localparam logic [CNT_W-1:0] PERIOD_DIV16 = 6'd16;

  typedef struct packed {
    logic       legal;
    logic [1:0] sel;
  } decode_t;

  function automatic decode_t decode_period(input logic [CNT_W-1:0] p);
    decode_t d;
    d.legal = 1'b1;
    d.sel   = 2'b00;
    case (p)
      PERIOD_DIV2:  d.sel = 2'b00;
      PERIOD_DIV4:  d.sel = 2'b01;
      PERIOD_DIV8:  d.sel = 2'b10;
      PERIOD_DIV16: d.sel = 2'b11;
      default:      d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/clock_ratio_detector_edge_period_counter.sv
// Two-stage sampler of the divided clock, rising-edge detect and a
// saturating period counter that restarts at 1 on every detected edge.
module edge_period_counter
  import clock_ratio_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clk_div_i,
  output logic             rise_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic             d0_q;
  logic             d1_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      d0_q  <= 1'b0;
      d1_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      d0_q  <= clk_div_i;
      d1_q  <= d0_q;
      cnt_q <= cnt_d;
    end
  end

  assign rise_o = d0_q & ~d1_q;

  always_comb begin
    cnt_d = cnt_q;
    if (rise_o) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/clock_ratio_detector.sv
// Recovers the divide ratio (2/4/8/16) of Clk_div relative to Clock_in.
// Define CLOCK_RATIO_DETECTOR_TIMEOUT_EN to enable loss-of-edge timeout and Lost.
module clock_ratio_detector
  import clock_ratio_pkg::*;
#(
  parameter int TIMEOUT    = 40,
  parameter int LOCK_COUNT = 2
) (
  input  logic       Clock_in,
  input  logic       Reset,
  input  logic       Clk_div,
  output logic [1:0] Sel_out,
  output logic       Valid,
  output logic       Error,
  output logic       Lost
);

`ifdef CLOCK_RATIO_DETECTOR_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  // LOCK_COUNT below 2 behaves as 2: a candidate always passes through CHECK.
  localparam logic [7:0] LOCK_LIM = 8'(LOCK_COUNT);

  logic             rise;
  logic [CNT_W-1:0] cnt;
  decode_t          dec;
  logic             timeout;

  state_e     state_q, state_d;
  logic [1:0] cand_q, cand_d;
  logic [7:0] match_q, match_d;
  logic [7:0] match_inc;
  logic [1:0] sel_q, sel_d;
  logic       valid_q, valid_d;
  logic       error_q, error_d;

  edge_period_counter u_edge_period_counter (
    .clk_i     (Clock_in),
    .rst_i     (Reset),
    .clk_div_i (Clk_div),
    .rise_o    (rise),
    .cnt_o     (cnt)
  );

  assign dec       = decode_period(cnt);
  assign match_inc = match_q + 8'd1;
  assign timeout   = TIMEOUT_EN & ~rise & (int'(cnt) >= TIMEOUT);

  always_ff @(posedge Clock_in or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cand_q  <= '0;
      match_q <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      match_q <= match_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  // Edge handling wins over timeout when both land in the same cycle.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    match_d = match_q;
    sel_d   = sel_q;
    if (rise) begin
      case (state_q)
        ST_IDLE: state_d = ST_MEASURE;
        ST_MEASURE: begin
          if (dec.legal) begin
            state_d = ST_CHECK;
            cand_d  = dec.sel;
            match_d = 8'd1;
          end
        end
        ST_CHECK: begin
          if (!dec.legal) begin
            state_d = ST_MEASURE;
            match_d = '0;
          end else if (dec.sel == cand_q) begin
            match_d = match_inc;
            if (match_inc >= LOCK_LIM) begin
              state_d = ST_LOCKED;
              sel_d   = cand_q;
            end
          end else begin
            cand_d  = dec.sel;
            match_d = 8'd1;
          end
        end
        ST_LOCKED: begin
          if (!dec.legal) begin
            state_d = ST_MEASURE;
            match_d = '0;
          end else if (dec.sel != sel_q) begin
            state_d = ST_CHECK;
            cand_d  = dec.sel;
            match_d = 8'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (timeout) begin
      state_d = ST_IDLE;
      match_d = '0;
    end
  end

  always_comb begin
    valid_d = (state_d == ST_LOCKED);
    error_d = rise & (state_q != ST_IDLE) & ~dec.legal;
  end

  assign Sel_out = sel_q;
  assign Valid   = valid_q;
  assign Error   = error_q;

`ifdef CLOCK_RATIO_DETECTOR_TIMEOUT_EN
  logic lost_q;

  always_ff @(posedge Clock_in or posedge Reset) begin
    if (Reset) begin
      lost_q <= 1'b0;
    end else if (rise) begin
      lost_q <= 1'b0;
    end else if (timeout) begin
      lost_q <= 1'b1;
    end
  end

  assign Lost = lost_q;
`else
  assign Lost = 1'b0;
`endif

endmodule
